sbus_arbiter: RTL and testbench

SBUS_ARBITER -- requirements
Module: sbus_arbiter

---
 rtl/sbus_arbiter.sv | 135 +++++++++++++
 tb/tb_sbus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_arbiter.sv
// rtl/sbus_arbiter.sv - IFU/LSU arbiter onto one SimpleBus memory port, one transaction outstanding.
// Optional ARB_ROUND_ROBIN_EN: alternate on simultaneous requests (default: LSU has fixed priority).
module sbus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_reqReady,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_reqReady,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_reqValid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_reqReady,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        owner_lsu;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        wen_q;
  logic [7:0]  cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_lsu;
`endif

  logic grant_ifu;
  logic grant_lsu;
  logic resp_ok;
  logic timeout;

  // Grants are gated by rst_n so the ready outputs are low while reset is held.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (ifu_reqValid && lsu_reqValid) begin
        grant_ifu = last_lsu;
        grant_lsu = !last_lsu;
      end else begin
        grant_ifu = ifu_reqValid;
        grant_lsu = lsu_reqValid;
      end
`else
      grant_lsu = lsu_reqValid;
      grant_ifu = ifu_reqValid && !lsu_reqValid;
`endif
    end
  end

  assign resp_ok = (state == WAIT) && mem_respValid;
  assign timeout = (state == WAIT) && !mem_respValid && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wen_q     <= 1'b0;
      cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_ifu || grant_lsu) begin
            owner_lsu <= grant_lsu;
            addr_q    <= grant_lsu ? lsu_addr : ifu_raddr;
            wen_q     <= grant_lsu & lsu_wen;
            wdata_q   <= grant_lsu ? lsu_wdata : 32'd0;
            wmask_q   <= grant_lsu ? lsu_wmask : 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu  <= grant_lsu;
`endif
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_reqReady) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (resp_ok || timeout) state <= IDLE;
          else                    cnt   <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifu_reqReady  = grant_ifu;
  assign lsu_reqReady  = grant_lsu;

  assign mem_reqValid  = (state == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // A response arriving on the timeout cycle wins, so timeout already excludes mem_respValid.
  assign ifu_respValid = (resp_ok || timeout) && !owner_lsu;
  assign ifu_err       = timeout && !owner_lsu;
  assign ifu_rdata     = (resp_ok && !owner_lsu) ? mem_rdata : 32'd0;
  assign lsu_respValid = (resp_ok || timeout) && owner_lsu;
  assign lsu_err       = timeout && owner_lsu;
  assign lsu_rdata     = (resp_ok && owner_lsu) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_sbus_arbiter.sv
// tb/tb_sbus_arbiter.sv - randomized self-checking bench for sbus_arbiter with a transaction-level model.
module tb_sbus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_raddr = '0;
  logic        ifu_reqReady, ifu_respValid, ifu_err;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid = 1'b0, lsu_wen = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_reqReady, lsu_respValid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_reqReady = 1'b0, mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sbus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_reqValid(ifu_reqValid), .ifu_raddr(ifu_raddr), .ifu_reqReady(ifu_reqReady),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_reqReady(lsu_reqReady),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_reqReady(mem_reqReady),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_last_lsu = 1'b1;

  logic        obs_iready, obs_lready, obs_after;
  logic [3:0]  obs_resp;
  logic [31:0] obs_irdata, obs_lrdata;
  logic [68:0] obs_fields;
  int          obs_changes, obs_ctrl_bad, obs_stray, obs_k;

  function automatic bit pick_lsu(input bit iv, input bit lv);
`ifdef ARB_ROUND_ROBIN_EN
    if (iv && lv) return !model_last_lsu;
`endif
    return lv;
  endfunction

  function automatic logic [68:0] cur_fields();
    return {mem_wen, mem_wmask, mem_addr, mem_wdata};
  endfunction

  // Drives one full request/response and records what the DUT did; scenario tasks judge it.
  task automatic run_txn(input bit iv, input bit lv, input bit wen, input logic [31:0] ia,
                         input logic [31:0] la, input logic [31:0] wd, input logic [3:0] wm,
                         input int req_wait, input int resp_wait, input logic [31:0] rd);
    @(negedge clk);
    ifu_reqValid = iv; ifu_raddr = ia;
    lsu_reqValid = lv; lsu_wen = wen; lsu_addr = la; lsu_wdata = wd; lsu_wmask = wm;
    mem_reqReady = 1'b0; mem_respValid = 1'b0;
    #1;
    obs_iready = ifu_reqReady; obs_lready = lsu_reqReady;
    @(posedge clk);
    #1;
    ifu_raddr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
    lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
    obs_changes = 0; obs_ctrl_bad = 0; obs_stray = 0; obs_k = -1;
    obs_resp = '0; obs_irdata = '0; obs_lrdata = '0; obs_fields = '0;
    for (int c = 0; c <= req_wait; c++) begin
      @(negedge clk);
      mem_reqReady  = (c == req_wait);
      mem_respValid = (c != req_wait) && ($urandom_range(1, 0) == 1);
      mem_rdata     = $urandom;
      #1;
      if (c == 0) obs_fields = cur_fields();
      else if (cur_fields() !== obs_fields) obs_changes++;
      if (mem_reqValid !== 1'b1) obs_ctrl_bad++;
      if ({ifu_respValid, ifu_err, lsu_respValid, lsu_err} !== 4'b0 ||
          ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0) obs_stray++;
    end
    for (int k = 0; k < TO + 3 && obs_k < 0; k++) begin
      @(negedge clk);
      mem_reqReady  = 1'b0;
      mem_respValid = (k == resp_wait);
      mem_rdata     = (k == resp_wait) ? rd : $urandom;
      #1;
      if (cur_fields() !== obs_fields) obs_changes++;
      if (mem_reqValid !== 1'b0) obs_ctrl_bad++;
      if (ifu_respValid === 1'b1 || lsu_respValid === 1'b1) begin
        obs_k = k;
        obs_resp = {ifu_respValid, ifu_err, lsu_respValid, lsu_err};
        obs_irdata = ifu_rdata; obs_lrdata = lsu_rdata;
      end else if ({ifu_err, lsu_err} !== 2'b0 || ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0) begin
        obs_stray++;
      end
    end
    @(posedge clk);
    #1;
    obs_after = ifu_respValid | lsu_respValid;
    mem_respValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_reqValid = 1'b1; lsu_reqValid = 1'b1; mem_respValid = 1'b1; mem_reqReady = 1'b1;
    mem_rdata = 32'h1234_5678;
    #12;
    n_tests++;
    if ({ifu_reqReady, lsu_reqReady} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {ifu_reqReady, lsu_reqReady});
    end
    n_tests++;
    if (mem_reqValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_reqValid: got %b expected 0", mem_reqValid);
    end
    n_tests++;
    if (cur_fields() !== 69'd0) begin
      n_fail++; $display("FAIL reset_mem_fields: got %h expected 0", cur_fields());
    end
    n_tests++;
    if ({ifu_respValid, ifu_err, lsu_respValid, lsu_err, ifu_rdata, lsu_rdata} !== 68'd0) begin
      n_fail++; $display("FAIL reset_resp: got %h expected 0",
                         {ifu_respValid, ifu_err, lsu_respValid, lsu_err, ifu_rdata, lsu_rdata});
    end
    @(negedge clk);
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0; mem_respValid = 1'b0; mem_reqReady = 1'b0;
    rst_n = 1'b1;
    model_last_lsu = 1'b1;
  endtask

  task automatic test_ifu_read();
    run_txn(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_0413);
    ifu_reqValid = 1'b0;
    model_last_lsu = 1'b0;
    n_tests++;
    if ({obs_iready, obs_lready} !== 2'b10) begin
      n_fail++; $display("FAIL ifu_read_grant: got %b expected 10", {obs_iready, obs_lready});
    end
    n_tests++;
    if (obs_fields !== {1'b0, 4'h0, 32'h8000_0000, 32'h0}) begin
      n_fail++; $display("FAIL ifu_read_fields: got %h expected %h", obs_fields,
                         {1'b0, 4'h0, 32'h8000_0000, 32'h0});
    end
    n_tests++;
    if (obs_k !== 1 || obs_resp !== 4'b1000 || obs_irdata !== 32'h0000_0413 || obs_lrdata !== 32'd0) begin
      n_fail++; $display("FAIL ifu_read_resp: got k=%0d resp=%b rdata=%h expected k=1 resp=1000 rdata=00000413",
                         obs_k, obs_resp, obs_irdata);
    end
    n_tests++;
    if (obs_after !== 1'b0 || obs_stray != 0) begin
      n_fail++; $display("FAIL ifu_read_pulse: got after=%b stray=%0d expected 0 0", obs_after, obs_stray);
    end
  endtask

  task automatic test_lsu_write();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h5555_AAAA);
    lsu_reqValid = 1'b0;
    model_last_lsu = 1'b1;
    n_tests++;
    if ({obs_iready, obs_lready} !== 2'b01) begin
      n_fail++; $display("FAIL lsu_write_grant: got %b expected 01", {obs_iready, obs_lready});
    end
    n_tests++;
    if (obs_fields !== {1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL lsu_write_fields: got %h expected %h", obs_fields,
                         {1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF});
    end
    n_tests++;
    if (obs_changes != 0 || obs_ctrl_bad != 0 || obs_stray != 0) begin
      n_fail++; $display("FAIL lsu_write_stable: got changes=%0d ctrl=%0d stray=%0d expected 0 0 0",
                         obs_changes, obs_ctrl_bad, obs_stray);
    end
    n_tests++;
    if (obs_k !== 0 || obs_resp !== 4'b0010 || obs_lrdata !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL lsu_write_resp: got k=%0d resp=%b rdata=%h expected k=0 resp=0010 rdata=5555aaaa",
                         obs_k, obs_resp, obs_lrdata);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_lsu;
    string order = "";
    string exp_order = "";
    for (int t = 0; t < 4; t++) begin
      exp_lsu = pick_lsu(1'b1, 1'b1);
      model_last_lsu = exp_lsu;
      exp_order = {exp_order, exp_lsu ? "L" : "I"};
      run_txn(1'b1, 1'b1, 1'b0, 32'h100 + 32'(t), 32'h200 + 32'(t), 32'h0, 4'h0,
              0, 0, 32'hB000_0000 + 32'(t));
      order = {order, obs_lready ? "L" : (obs_iready ? "I" : "-")};
      n_tests++;
      if ({obs_iready, obs_lready} !== {!exp_lsu, exp_lsu}) begin
        n_fail++; $display("FAIL b2b_grant%0d: got %b expected %b", t, {obs_iready, obs_lready},
                           {!exp_lsu, exp_lsu});
      end
    end
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    n_tests++;
    if (order != exp_order) begin
      n_fail++; $display("FAIL b2b_order: got %s expected %s", order, exp_order);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 32'h0, 4'h0, 1, 100, 32'hFFFF_FFFF);
    ifu_reqValid = 1'b0;
    model_last_lsu = 1'b0;
    n_tests++;
    if (obs_k !== TO - 1 || obs_resp !== 4'b1100 || obs_irdata !== 32'd0) begin
      n_fail++; $display("FAIL timeout_resp: got k=%0d resp=%b rdata=%h expected k=%0d resp=1100 rdata=0",
                         obs_k, obs_resp, obs_irdata, TO - 1);
    end
    n_tests++;
    if (obs_after !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got %b expected 0", obs_after);
    end
  endtask

  task automatic test_timeout_race();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2000, 32'h0, 4'h0, 0, TO - 1, 32'hCAFE_F00D);
    lsu_reqValid = 1'b0;
    model_last_lsu = 1'b1;
    n_tests++;
    if (obs_lready !== 1'b1) begin
      n_fail++; $display("FAIL race_grant: got %b expected 1", obs_lready);
    end
    n_tests++;
    if (obs_k !== TO - 1 || obs_resp !== 4'b0010 || obs_lrdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL race_resp: got k=%0d resp=%b rdata=%h expected k=%0d resp=0010 rdata=cafef00d",
                         obs_k, obs_resp, obs_lrdata, TO - 1);
    end
  endtask

  task automatic test_reset_mid();
    int strays = 0;
    @(negedge clk);
    ifu_reqValid = 1'b1; ifu_raddr = 32'h8000_0300;
    @(negedge clk);
    ifu_reqValid = 1'b0; mem_reqReady = 1'b1;
    @(negedge clk);
    mem_reqReady = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_reqValid, ifu_respValid, lsu_respValid, ifu_reqReady, lsu_reqReady} !== 5'b0 ||
        cur_fields() !== 69'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got ctl=%b fields=%h expected 0",
                         {mem_reqValid, ifu_respValid, lsu_respValid, ifu_reqReady, lsu_reqReady}, cur_fields());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last_lsu = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_respValid = 1'b1; mem_rdata = $urandom;
      #1;
      if (ifu_respValid !== 1'b0 || lsu_respValid !== 1'b0 || ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0)
        strays++;
    end
    mem_respValid = 1'b0;
    n_tests++;
    if (strays != 0) begin
      n_fail++; $display("FAIL midreset_stray: got %0d responses expected 0", strays);
    end
    run_txn(1'b1, 1'b0, 1'b0, 32'h8000_0400, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0000_0013);
    ifu_reqValid = 1'b0;
    model_last_lsu = 1'b0;
    n_tests++;
    if (obs_iready !== 1'b1 || obs_resp !== 4'b1000 || obs_irdata !== 32'h0000_0013) begin
      n_fail++; $display("FAIL midreset_next: got ready=%b resp=%b rdata=%h expected 1 1000 00000013",
                         obs_iready, obs_resp, obs_irdata);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit iv, lv, wen, exp_lsu, exp_err;
      logic [31:0] ia, la, wd, rd, exp_rd;
      logic [3:0] wm;
      logic [68:0] exp_fields;
      int rw, sw, exp_k;
      iv = 1'($urandom); lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      wen = 1'($urandom); ia = $urandom; la = $urandom; wd = $urandom; wm = 4'($urandom);
      rd = $urandom; rw = $urandom_range(3, 0); sw = $urandom_range(TO + 1, 0);
      exp_lsu = pick_lsu(iv, lv);
      model_last_lsu = exp_lsu;
      exp_fields = exp_lsu ? {wen, wm, la, wd} : {1'b0, 4'h0, ia, 32'h0};
      exp_err = (sw > TO - 1);
      exp_k = exp_err ? TO - 1 : sw;
      exp_rd = exp_err ? 32'd0 : rd;
      run_txn(iv, lv, wen, ia, la, wd, wm, rw, sw, rd);
      n_tests++;
      if ({obs_iready, obs_lready} !== {!exp_lsu, exp_lsu}) begin
        n_fail++; $display("FAIL rand%0d_grant: got %b expected %b", t, {obs_iready, obs_lready},
                           {!exp_lsu, exp_lsu});
      end
      n_tests++;
      if (obs_fields !== exp_fields) begin
        n_fail++; $display("FAIL rand%0d_fields: got %h expected %h", t, obs_fields, exp_fields);
      end
      n_tests++;
      if (obs_changes != 0 || obs_ctrl_bad != 0 || obs_stray != 0 || obs_after !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_protocol: got changes=%0d ctrl=%0d stray=%0d after=%b expected 0",
                           t, obs_changes, obs_ctrl_bad, obs_stray, obs_after);
      end
      n_tests++;
      if (obs_k !== exp_k) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, obs_k, exp_k);
      end
      n_tests++;
      if (obs_resp !== (exp_lsu ? {2'b00, 1'b1, exp_err} : {1'b1, exp_err, 2'b00}) ||
          (exp_lsu ? obs_lrdata : obs_irdata) !== exp_rd ||
          (exp_lsu ? obs_irdata : obs_lrdata) !== 32'd0) begin
        n_fail++; $display("FAIL rand%0d_resp: got resp=%b irdata=%h lrdata=%h expected lsu=%b err=%b rdata=%h",
                           t, obs_resp, obs_irdata, obs_lrdata, exp_lsu, exp_err, exp_rd);
      end
    end
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
